// File: rtl/mult_batch_scheduler_if.sv
// Requester-side and multiplier-side signals of the batch scheduler.
// The scheduler uses the slave modport. The environment uses the master modport.
interface mult_batch_scheduler_if #(
  parameter int WIDTH = 32
);
  logic [1:0]       req_valid;
  logic [31:0]      req_op0;
  logic [31:0]      req_op1;
  logic [1:0]       req_ready;
  logic [1:0]       res_valid;
  logic [WIDTH-1:0] res_data;
  logic [1:0]       batch_done;
  logic [1:0]       batch_err;
  logic             busy;
  logic             EN_mult;
  logic [15:0]      mult_input0;
  logic [15:0]      mult_input1;
  logic             RDY_mult;
  logic             EN_blockRead;
  logic             VALID_memVal;
  logic [WIDTH-1:0] memVal_data;

  modport slave (
    input  req_valid, req_op0, req_op1, RDY_mult, VALID_memVal, memVal_data,
    output req_ready, res_valid, res_data, batch_done, batch_err, busy,
           EN_mult, mult_input0, mult_input1, EN_blockRead
  );

  modport master (
    output req_valid, req_op0, req_op1, RDY_mult, VALID_memVal, memVal_data,
    input  req_ready, res_valid, res_data, batch_done, batch_err, busy,
           EN_mult, mult_input0, mult_input1, EN_blockRead
  );
endinterface

// File: rtl/mult_batch_scheduler.sv
// Two-channel batch scheduler in front of a shared multiplier/product memory.
// It feeds one DEPTH-pair batch, waits for the memory to fill, then drains the products to the owning channel.

// Per-channel gating: handshakes, operand slice and the registered done/err pulses.
module mult_batch_scheduler_lane (
  input  logic        clk,
  input  logic        rst,
  input  logic        own,
  input  logic        feed,
  input  logic        drain,
  input  logic        xfer,
  input  logic        mem_valid,
  input  logic        done_set,
  input  logic        err_set,
  input  logic [15:0] op0,
  input  logic [15:0] op1,
  output logic        req_ready,
  output logic        res_valid,
  output logic        batch_done,
  output logic        batch_err,
  output logic [15:0] in0,
  output logic [15:0] in1
);
  logic act_feed;

  assign act_feed  = own & feed;
  assign req_ready = act_feed & xfer;
  assign res_valid = own & drain & mem_valid;
  assign in0       = act_feed ? op0 : '0;
  assign in1       = act_feed ? op1 : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      batch_done <= 1'b0;
      batch_err  <= 1'b0;
    end else begin
      batch_done <= own & done_set;
      batch_err  <= own & err_set;
    end
  end
endmodule

module mult_batch_scheduler #(
  parameter int LOGDEPTH = 6,
  parameter int WIDTH    = 32,
  parameter int TIMEOUT  = 255
) (
  input logic                   clk,
  input logic                   rst,
  mult_batch_scheduler_if.slave bus
);
  localparam int                NUM_CH = 2;
  localparam int                DEPTH  = 2 ** LOGDEPTH;
  localparam logic [LOGDEPTH:0] LAST   = (LOGDEPTH+1)'(DEPTH - 1);
  localparam logic [LOGDEPTH:0] ONE    = (LOGDEPTH+1)'(1);
  localparam logic [7:0]        WD_MAX = 8'(TIMEOUT);

  typedef enum logic [2:0] {IDLE, FEED, WAIT_FULL, READ_REQ, DRAIN} state_t;

  state_t            state, state_nx;
  logic              owner, owner_nx;
  logic              last_grant, last_grant_nx;
  logic [LOGDEPTH:0] fed_cnt, fed_nx;
  logic [LOGDEPTH:0] beat_cnt, beat_nx;
  logic [7:0]        wd_cnt, wd_nx;
  logic              xfer, done_set, err_set, blk_rd, grant;
  logic              in_feed, in_drain;
  logic [WIDTH-1:0]  res_mux;

  logic [NUM_CH-1:0]       own, lane_rdy, lane_rv, lane_done, lane_err;
  logic [NUM_CH-1:0][15:0] op0_v, op1_v, lane_in0, lane_in1;
  logic [15:0]             in0_or, in1_or;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      fed_cnt    <= '0;
      beat_cnt   <= '0;
      wd_cnt     <= '0;
    end else begin
      state      <= state_nx;
      owner      <= owner_nx;
      last_grant <= last_grant_nx;
      fed_cnt    <= fed_nx;
      beat_cnt   <= beat_nx;
      wd_cnt     <= wd_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    owner_nx      = owner;
    last_grant_nx = last_grant;
    fed_nx        = fed_cnt;
    beat_nx       = beat_cnt;
    wd_nx         = wd_cnt;
    xfer          = 1'b0;
    done_set      = 1'b0;
    err_set       = 1'b0;
    blk_rd        = 1'b0;
    grant         = 1'b0;
    case (state)
      IDLE: begin
        if (|bus.req_valid) begin
          // On a tie the channel that did not win last time gets the grant.
          grant         = (&bus.req_valid) ? ~last_grant : bus.req_valid[1];
          owner_nx      = grant;
          last_grant_nx = grant;
          fed_nx        = '0;
          state_nx      = FEED;
        end
      end
      FEED: begin
        xfer = bus.req_valid[owner] & bus.RDY_mult;
        if (xfer) begin
          fed_nx = fed_cnt + ONE;
          if (fed_cnt == LAST) begin
            state_nx = WAIT_FULL;
            wd_nx    = '0;
          end
        end
      end
      WAIT_FULL: begin
        wd_nx = wd_cnt + 8'd1;
        // RDY_mult dropping means the memory is full, and that wins over the watchdog.
        if (!bus.RDY_mult) begin
          state_nx = READ_REQ;
        end else if (wd_cnt == WD_MAX) begin
          err_set  = 1'b1;
          state_nx = IDLE;
        end
      end
      READ_REQ: begin
        blk_rd   = 1'b1;
        beat_nx  = '0;
        state_nx = DRAIN;
      end
      DRAIN: begin
        if (bus.VALID_memVal) begin
          beat_nx = beat_cnt + ONE;
          if (beat_cnt == LAST) begin
            done_set = 1'b1;
            state_nx = IDLE;
          end
        end else if (beat_cnt != '0) begin
          done_set = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign in_feed  = (state == FEED);
  assign in_drain = (state == DRAIN);
  assign op0_v    = bus.req_op0;
  assign op1_v    = bus.req_op1;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    assign own[c] = (owner == 1'(c));
    mult_batch_scheduler_lane u_lane (
      .clk       (clk),
      .rst       (rst),
      .own       (own[c]),
      .feed      (in_feed),
      .drain     (in_drain),
      .xfer      (xfer),
      .mem_valid (bus.VALID_memVal),
      .done_set  (done_set),
      .err_set   (err_set),
      .op0       (op0_v[c]),
      .op1       (op1_v[c]),
      .req_ready (lane_rdy[c]),
      .res_valid (lane_rv[c]),
      .batch_done(lane_done[c]),
      .batch_err (lane_err[c]),
      .in0       (lane_in0[c]),
      .in1       (lane_in1[c])
    );
  end

  always_comb begin
    in0_or = '0;
    in1_or = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      in0_or = in0_or | lane_in0[c];
      in1_or = in1_or | lane_in1[c];
    end
  end

  assign res_mux          = in_drain ? bus.memVal_data : '0;
  assign bus.res_data     = res_mux;
  assign bus.req_ready    = lane_rdy;
  assign bus.res_valid    = lane_rv;
  assign bus.batch_done   = lane_done;
  assign bus.batch_err    = lane_err;
  assign bus.busy         = (state != IDLE);
  assign bus.EN_mult      = xfer;
  assign bus.EN_blockRead = blk_rd;
  assign bus.mult_input0  = in0_or;
  assign bus.mult_input1  = in1_or;
endmodule

// File: tb/tb_mult_batch_scheduler.sv
// Scenario bench for mult_batch_scheduler with a behavioural multiplier/memory model.
// Operand and product scoreboards are filled as stimulus is driven and drained as the DUT responds.
module tb_mult_batch_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mult_batch_scheduler_if #(.WIDTH(32)) bus ();

  mult_batch_scheduler #(.LOGDEPTH(6), .WIDTH(32), .TIMEOUT(255)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_chk  = 0;
  int n_pass = 0;
  logic [31:0] in_q[$];
  logic [31:0] res_q[$];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_chk);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present pairs op0=i, op1=2 on channel ch until 64 have been accepted.
  task automatic feed(input int ch, input logic [1:0] bg, input bit tog, input bit gaps,
                      output int nx, output int bad, output int mis);
    int i;
    bit v;
    logic [31:0] e;
    nx = 0; bad = 0; mis = 0; i = 0;
    in_q.delete();
    in_q.push_back({16'(0), 16'd2});
    for (int cyc = 0; cyc < 3000 && nx < 64; cyc++) begin
      step();
      bus.RDY_mult  = tog ? (cyc % 2 == 0) : 1'b1;
      v             = gaps ? (cyc % 8 < 3) : 1'b1;
      bus.req_valid = bg;
      if (v) bus.req_valid[ch] = 1'b1;
      bus.req_op0   = (ch == 1) ? {16'(i), 16'hdead} : {16'hbeef, 16'(i)};
      bus.req_op1   = (ch == 1) ? {16'd2, 16'h1234} : {16'h4321, 16'd2};
      @(negedge clk);
      if (bus.EN_mult && !bus.RDY_mult) bad++;
      if (bus.req_ready[ch] !== bus.EN_mult || bus.req_ready[1-ch] !== 1'b0) bad++;
      if (bus.EN_mult) begin
        e = in_q.pop_front();
        if ({bus.mult_input0, bus.mult_input1} !== e) mis++;
        nx++; i++;
        in_q.push_back({16'(i), 16'd2});
      end
    end
  endtask

  // Memory model: drop RDY_mult, wait for the block read, then return nb beats.
  task automatic drain(input int ch, input int nb, input logic [1:0] bg,
                       output int nres, output int mis, output int oth, output int nblk,
                       output int done_at, output logic busy_d);
    int b, rel;
    bit started;
    logic [31:0] d, e;
    b = 0; rel = -1; started = 0;
    nres = 0; mis = 0; oth = 0; nblk = 0; done_at = -1; busy_d = 1'b1;
    res_q.delete();
    for (int c = 0; c < 300 && done_at < 0; c++) begin
      step();
      bus.req_valid    = bg;
      bus.RDY_mult     = 1'b0;
      bus.VALID_memVal = 1'b0;
      if (started) rel++;
      if (started && b < nb) begin
        d = $urandom;
        bus.VALID_memVal = 1'b1;
        bus.memVal_data  = d;
        res_q.push_back(d);
        b++;
      end
      @(negedge clk);
      if (bus.res_valid[ch]) begin
        nres++;
        if (res_q.size() == 0) mis++;
        else begin
          e = res_q.pop_front();
          if (bus.res_data !== e) mis++;
        end
      end
      if (bus.res_valid[1-ch] || bus.batch_done[1-ch] || bus.batch_err !== 2'b00 || bus.EN_mult) oth++;
      if (bus.EN_blockRead) begin nblk++; started = 1; end
      if (bus.batch_done[ch]) begin done_at = rel; busy_d = bus.busy; end
    end
    bus.VALID_memVal = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = 2'b11; bus.req_op0 = 32'hffff_ffff; bus.req_op1 = 32'hffff_ffff;
    bus.RDY_mult = 1'b1; bus.VALID_memVal = 1'b1; bus.memVal_data = 32'hdead_beef;
    repeat (3) step();
    @(negedge clk);
    n_chk++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else n_pass++;
    n_chk++; if (bus.EN_mult !== 1'b0 || bus.EN_blockRead !== 1'b0) $display("FAIL reset_en: got %b%b want 00", bus.EN_mult, bus.EN_blockRead); else n_pass++;
    n_chk++; if (bus.req_ready !== 2'b00 || bus.res_valid !== 2'b00) $display("FAIL reset_hs: got %b %b want 00 00", bus.req_ready, bus.res_valid); else n_pass++;
    n_chk++; if (bus.res_data !== 32'h0) $display("FAIL reset_res_data: got %h want 0", bus.res_data); else n_pass++;
    n_chk++; if ({bus.mult_input0, bus.mult_input1} !== 32'h0) $display("FAIL reset_mult_in: got %h want 0", {bus.mult_input0, bus.mult_input1}); else n_pass++;
    n_chk++; if ({bus.batch_done, bus.batch_err} !== 4'h0) $display("FAIL reset_pulses: got %b want 0000", {bus.batch_done, bus.batch_err}); else n_pass++;
    step();
    rst = 1'b0; bus.req_valid = 2'b00; bus.VALID_memVal = 1'b0;
  endtask

  task automatic test_single();
    int nx, bad, mis, nres, rmis, oth, nblk, done_at;
    logic busy_d;
    feed(0, 2'b00, 0, 0, nx, bad, mis);
    drain(0, 63, 2'b00, nres, rmis, oth, nblk, done_at, busy_d);
    n_chk++; if (nx !== 64) $display("FAIL single_feed_count: got %0d want 64", nx); else n_pass++;
    n_chk++; if (bad !== 0) $display("FAIL single_feed_handshake: got %0d errors want 0", bad); else n_pass++;
    n_chk++; if (mis !== 0) $display("FAIL single_mult_input: got %0d mismatches want 0", mis); else n_pass++;
    n_chk++; if (nblk !== 1) $display("FAIL single_blockread: got %0d pulses want 1", nblk); else n_pass++;
    n_chk++; if (nres !== 63) $display("FAIL single_res_beats: got %0d want 63", nres); else n_pass++;
    n_chk++; if (rmis !== 0) $display("FAIL single_res_data: got %0d mismatches want 0", rmis); else n_pass++;
    n_chk++; if (oth !== 0) $display("FAIL single_other_ch: got %0d events want 0", oth); else n_pass++;
    n_chk++; if (done_at !== 64) $display("FAIL single_done_time: got %0d want 64", done_at); else n_pass++;
    n_chk++; if (busy_d !== 1'b0) $display("FAIL single_busy_at_done: got %b want 0", busy_d); else n_pass++;
  endtask

  task automatic test_tie();
    int nx, bad, mis, nres, rmis, oth, nblk, done_at;
    logic busy_d;
    rst = 1'b1; step(); step(); rst = 1'b0;
    feed(0, 2'b11, 0, 0, nx, bad, mis);
    n_chk++; if (nx !== 64 || bad !== 0 || mis !== 0) $display("FAIL tie_first_ch0: got nx=%0d bad=%0d mis=%0d want 64/0/0", nx, bad, mis); else n_pass++;
    drain(0, 63, 2'b11, nres, rmis, oth, nblk, done_at, busy_d);
    n_chk++; if (done_at !== 64 || nres !== 63) $display("FAIL tie_first_done: got done_at=%0d nres=%0d want 64/63", done_at, nres); else n_pass++;
    feed(1, 2'b11, 0, 0, nx, bad, mis);
    n_chk++; if (nx !== 64 || bad !== 0 || mis !== 0) $display("FAIL tie_second_ch1: got nx=%0d bad=%0d mis=%0d want 64/0/0", nx, bad, mis); else n_pass++;
    drain(1, 64, 2'b11, nres, rmis, oth, nblk, done_at, busy_d);
    n_chk++; if (done_at !== 64 || nres !== 64 || rmis !== 0 || oth !== 0) $display("FAIL tie_second_drain: got done_at=%0d nres=%0d mis=%0d oth=%0d want 64/64/0/0", done_at, nres, rmis, oth); else n_pass++;
    feed(0, 2'b11, 0, 0, nx, bad, mis);
    n_chk++; if (nx !== 64 || bad !== 0 || mis !== 0) $display("FAIL tie_third_ch0: got nx=%0d bad=%0d mis=%0d want 64/0/0", nx, bad, mis); else n_pass++;
    drain(0, 64, 2'b00, nres, rmis, oth, nblk, done_at, busy_d);
    n_chk++; if (done_at !== 64) $display("FAIL tie_third_done: got %0d want 64", done_at); else n_pass++;
  endtask

  task automatic test_backpressure();
    int nx, bad, mis, nres, rmis, oth, nblk, done_at;
    logic busy_d;
    feed(1, 2'b00, 1, 1, nx, bad, mis);
    n_chk++; if (nx !== 64) $display("FAIL bp_feed_count: got %0d want 64", nx); else n_pass++;
    n_chk++; if (bad !== 0) $display("FAIL bp_handshake: got %0d errors want 0", bad); else n_pass++;
    n_chk++; if (mis !== 0) $display("FAIL bp_mult_input: got %0d mismatches want 0", mis); else n_pass++;
    drain(1, 64, 2'b00, nres, rmis, oth, nblk, done_at, busy_d);
    n_chk++; if (nblk !== 1 || oth !== 0) $display("FAIL bp_after_feed: got blk=%0d oth=%0d want 1/0", nblk, oth); else n_pass++;
    n_chk++; if (nres !== 64 || rmis !== 0 || done_at !== 64) $display("FAIL bp_drain: got nres=%0d mis=%0d done_at=%0d want 64/0/64", nres, rmis, done_at); else n_pass++;
  endtask

  task automatic test_timeout();
    int nx, bad, mis, err_at, nblk, oth;
    logic busy_e;
    err_at = -1; nblk = 0; oth = 0; busy_e = 1'b1;
    feed(1, 2'b00, 0, 0, nx, bad, mis);
    n_chk++; if (nx !== 64 || bad !== 0) $display("FAIL to_feed: got nx=%0d bad=%0d want 64/0", nx, bad); else n_pass++;
    for (int k = 0; k < 400 && err_at < 0; k++) begin
      step();
      bus.req_valid = 2'b00; bus.RDY_mult = 1'b1;
      @(negedge clk);
      if (bus.EN_blockRead) nblk++;
      if (bus.EN_mult || bus.batch_err[0] || bus.batch_done !== 2'b00) oth++;
      if (bus.batch_err[1]) begin err_at = k; busy_e = bus.busy; end
    end
    n_chk++; if (err_at !== 256) $display("FAIL to_err_time: got %0d want 256", err_at); else n_pass++;
    n_chk++; if (nblk !== 0) $display("FAIL to_blockread: got %0d want 0", nblk); else n_pass++;
    n_chk++; if (oth !== 0) $display("FAIL to_spurious: got %0d want 0", oth); else n_pass++;
    n_chk++; if (busy_e !== 1'b0) $display("FAIL to_busy: got %b want 0", busy_e); else n_pass++;
    step(); @(negedge clk);
    n_chk++; if (bus.batch_err !== 2'b00) $display("FAIL to_err_pulse_len: got %b want 00", bus.batch_err); else n_pass++;
  endtask

  task automatic test_short_drain();
    int nx, bad, mis, nres, rmis, oth, nblk, done_at;
    logic busy_d;
    feed(0, 2'b00, 0, 0, nx, bad, mis);
    drain(0, 64, 2'b00, nres, rmis, oth, nblk, done_at, busy_d);
    n_chk++; if (nres !== 64 || rmis !== 0) $display("FAIL full_drain_beats: got nres=%0d mis=%0d want 64/0", nres, rmis); else n_pass++;
    n_chk++; if (done_at !== 64 || busy_d !== 1'b0) $display("FAIL full_drain_done: got done_at=%0d busy=%b want 64/0", done_at, busy_d); else n_pass++;
    step();
    bus.req_valid = 2'b00; bus.VALID_memVal = 1'b1; bus.memVal_data = 32'h1357_9bdf;
    @(negedge clk);
    n_chk++; if (bus.res_valid !== 2'b00 || bus.res_data !== 32'h0) $display("FAIL stray_beat: got rv=%b data=%h want 00/0", bus.res_valid, bus.res_data); else n_pass++;
    step();
    bus.VALID_memVal = 1'b0;
  endtask

  task automatic test_reset_mid_drain();
    int nx, bad, mis, ndone;
    bit seen;
    seen = 0; ndone = 0;
    feed(0, 2'b00, 0, 0, nx, bad, mis);
    for (int c = 0; c < 10 && !seen; c++) begin
      step();
      bus.req_valid = 2'b00; bus.RDY_mult = 1'b0;
      @(negedge clk);
      if (bus.EN_blockRead) seen = 1;
    end
    n_chk++; if (seen !== 1'b1) $display("FAIL rmd_blockread: got %b want 1", seen); else n_pass++;
    for (int b = 0; b < 10; b++) begin
      step();
      bus.VALID_memVal = 1'b1; bus.memVal_data = 32'(b + 100);
    end
    step();
    rst = 1'b1; bus.memVal_data = 32'd110;
    step();
    rst = 1'b0;
    @(negedge clk);
    n_chk++; if (bus.busy !== 1'b0) $display("FAIL rmd_busy: got %b want 0", bus.busy); else n_pass++;
    n_chk++; if (bus.res_valid !== 2'b00 || bus.res_data !== 32'h0) $display("FAIL rmd_res: got rv=%b data=%h want 00/0", bus.res_valid, bus.res_data); else n_pass++;
    n_chk++; if (bus.EN_blockRead !== 1'b0 || bus.EN_mult !== 1'b0) $display("FAIL rmd_en: got %b%b want 00", bus.EN_blockRead, bus.EN_mult); else n_pass++;
    bus.VALID_memVal = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      @(negedge clk);
      if (bus.batch_done !== 2'b00 || bus.batch_err !== 2'b00) ndone++;
    end
    n_chk++; if (ndone !== 0) $display("FAIL rmd_no_done: got %0d pulses want 0", ndone); else n_pass++;
    step();
    bus.req_valid = 2'b11; bus.RDY_mult = 1'b1;
    bus.req_op0 = {16'haaaa, 16'h0005}; bus.req_op1 = {16'hbbbb, 16'h0002};
    step();
    @(negedge clk);
    n_chk++; if (bus.req_ready !== 2'b01) $display("FAIL rmd_regrant_ch0: got %b want 01", bus.req_ready); else n_pass++;
    n_chk++; if (bus.mult_input0 !== 16'h0005) $display("FAIL rmd_regrant_op: got %h want 0005", bus.mult_input0); else n_pass++;
    step();
    rst = 1'b1; bus.req_valid = 2'b00;
    step();
    rst = 1'b0;
  endtask

  initial begin
    bus.req_valid = 2'b00; bus.req_op0 = '0; bus.req_op1 = '0;
    bus.RDY_mult = 1'b1; bus.VALID_memVal = 1'b0; bus.memVal_data = '0;
    test_reset();
    test_single();
    test_tie();
    test_backpressure();
    test_timeout();
    test_short_drain();
    test_reset_mid_drain();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
